// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//   Boot-time writer for the core's instruction memory. It takes a valid/ready
//   stream of 32-bit instruction words and writes them to consecutive imem word
//   addresses. It holds the MIPS core in reset until the last word has been
//   written, then keeps it in reset for RST_HOLD more cycles before releasing
//   it. A program that does not fit in imem puts the loader in a terminal error
//   state and the core stays held.
//
//   Parameters
//     ADDR_W    imem word-address width; capacity DEPTH = 2**ADDR_W words
//     RST_HOLD  cycles cpu_rst stays high after the last imem write (>=1)
//
//   Ports
//     clk, rst     rising-edge clock, synchronous active-high reset
//     ld_valid     ld_data/ld_last valid
//     ld_ready     loader accepts a word this cycle
//     ld_data      instruction word
//     ld_last      marks the final word of the program
//     imem_we      imem write strobe, one cycle per word
//     imem_addr    imem word address
//     imem_wdata   imem write data
//     cpu_rst      reset to the core; high = core held
//     load_done    sticky: program loaded, core released
//     load_err     sticky: capacity overflow, core held
//     word_count   words accepted since reset (saturates at DEPTH)
//     csum         running sum of accepted words (only with LOADER_CHECKSUM_EN)
//
//   Build option
//     LOADER_CHECKSUM_EN  adds the csum output and its accumulator
// ----------------------------------------------------------------------------
module imem_loader #(
   parameter int ADDR_W   = 8,
   parameter int RST_HOLD = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [31:0]       ld_data,
   input  logic              ld_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              load_done,
   output logic              load_err,
`ifdef LOADER_CHECKSUM_EN
   output logic [31:0]       csum,
`endif
   output logic [ADDR_W:0]   word_count
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int HW    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

   localparam logic [ADDR_W:0] TOP_ADDR  = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
   localparam logic [HW-1:0]   HOLD_LAST = HW'(RST_HOLD - 1);

   typedef enum logic [1:0] {
      S_LOAD    = 2'd0,
      S_RELEASE = 2'd1,
      S_RUN     = 2'd2,
      S_ERR     = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [HW-1:0]   hold_cnt;
   logic            xfer;
   logic            at_top;

   assign xfer   = ld_valid && ld_ready;
   // The word being accepted lands on the last imem address.
   assign at_top = (word_count == TOP_ADDR);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (rst) state <= S_LOAD;
      else     state <= state_nxt;
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_LOAD: begin
            if (xfer) begin
               if (ld_last)     state_nxt = S_RELEASE;
               else if (at_top) state_nxt = S_ERR;
            end
         end
         // The first RELEASE cycle is the one in which the last write is on
         // the imem port, so the core sees RST_HOLD held cycles counted from it.
         S_RELEASE: if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
         S_RUN:     state_nxt = S_RUN;
         S_ERR:     state_nxt = S_ERR;
         default:   state_nxt = S_LOAD;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      ld_ready  = 1'b0;
      cpu_rst   = 1'b1;
      load_done = 1'b0;
      load_err  = 1'b0;
      case (state)
         S_LOAD: ld_ready = !rst;
         S_RUN: begin
            cpu_rst   = 1'b0;
            load_done = 1'b1;
         end
         S_ERR:   load_err = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- hold counter
   always_ff @(posedge clk) begin
      if (rst)                     hold_cnt <= '0;
      else if (state == S_RELEASE) hold_cnt <= hold_cnt + HW'(1);
      else                         hold_cnt <= '0;
   end

   // ---------------------------------------------------------------- write port
   always_ff @(posedge clk) begin
      if (rst) begin
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else if (xfer) begin
         imem_we    <= 1'b1;
         imem_addr  <= word_count[ADDR_W-1:0];
         imem_wdata <= ld_data;
      end else begin
         imem_we    <= 1'b0;
      end
   end

   // Transfers stop once the last address is used, so the count can reach
   // DEPTH but never wrap; the explicit guard keeps that true by construction.
   always_ff @(posedge clk) begin
      if (rst)                             word_count <= '0;
      else if (xfer && word_count != FULL_CNT) word_count <= word_count + 1'b1;
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (rst)       csum <= '0;
      else if (xfer) csum <= csum + ld_data;
   end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader. Two instances share clk/rst: an 8-bit
//   address build for normal loads and a 2-bit address build (4 words) for the
//   capacity boundary. Inputs change and outputs are sampled 1 time unit after
//   each rising edge.
// ----------------------------------------------------------------------------
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        v8 = 1'b0, l8 = 1'b0;
   logic [31:0] d8 = '0;
   logic        rdy8, we8, crst8, done8, err8;
   logic [7:0]  addr8;
   logic [31:0] wd8;
   logic [8:0]  cnt8;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0] csum8;
`endif

   logic        v2 = 1'b0, l2 = 1'b0;
   logic [31:0] d2 = '0;
   logic        rdy2, we2, crst2, done2, err2;
   logic [1:0]  addr2;
   logic [31:0] wd2;
   logic [2:0]  cnt2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   imem_loader #(.ADDR_W(8), .RST_HOLD(2)) dut8 (
      .clk(clk), .rst(rst), .ld_valid(v8), .ld_ready(rdy8), .ld_data(d8),
      .ld_last(l8), .imem_we(we8), .imem_addr(addr8), .imem_wdata(wd8),
      .cpu_rst(crst8), .load_done(done8), .load_err(err8),
`ifdef LOADER_CHECKSUM_EN
      .csum(csum8),
`endif
      .word_count(cnt8)
   );

   imem_loader #(.ADDR_W(2), .RST_HOLD(2)) dut2 (
      .clk(clk), .rst(rst), .ld_valid(v2), .ld_ready(rdy2), .ld_data(d2),
      .ld_last(l2), .imem_we(we2), .imem_addr(addr2), .imem_wdata(wd2),
      .cpu_rst(crst2), .load_done(done2), .load_err(err2),
      .word_count(cnt2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      v8 = 1'b0; l8 = 1'b0; v2 = 1'b0; l2 = 1'b0;
      tick();
      tick();
   endtask

   logic [31:0] prog [4];

   initial begin
      prog[0] = 32'h20080005; prog[1] = 32'h20090003;
      prog[2] = 32'h01095020; prog[3] = 32'h00000000;
      #1;

      // ---- 1: reset values, then a 4-word back-to-back load
      do_reset();
      check("rst_we",    32'(we8),    32'd0);
      check("rst_addr",  32'(addr8),  32'd0);
      check("rst_wdata", wd8,         32'd0);
      check("rst_cpu",   32'(crst8),  32'd1);
      check("rst_done",  32'(done8),  32'd0);
      check("rst_err",   32'(err8),   32'd0);
      check("rst_cnt",   32'(cnt8),   32'd0);
      check("rst_ready", 32'(rdy8),   32'd0);
      rst = 1'b0;
      #1;
      check("ready_up",  32'(rdy8),   32'd1);
      for (int i = 0; i < 4; i++) begin
         v8 = 1'b1; d8 = prog[i]; l8 = (i == 3);
         tick();
         check($sformatf("t1_we%0d", i),   32'(we8),   32'd1);
         check($sformatf("t1_addr%0d", i), 32'(addr8), 32'(i));
         check($sformatf("t1_data%0d", i), wd8,        prog[i]);
         check($sformatf("t1_cnt%0d", i),  32'(cnt8),  32'(i + 1));
      end
      v8 = 1'b0; l8 = 1'b0;
      check("t1_ready_rel", 32'(rdy8),  32'd0);
      check("t1_cpu_c0",    32'(crst8), 32'd1);
      tick();
      check("t1_cpu_c1",    32'(crst8), 32'd1);
      check("t1_we_c1",     32'(we8),   32'd0);
      check("t1_done_c1",   32'(done8), 32'd0);
      tick();
      check("t1_cpu_c2",    32'(crst8), 32'd0);
      check("t1_done_c2",   32'(done8), 32'd1);
      check("t1_err_c2",    32'(err8),  32'd0);
      check("t1_cnt_end",   32'(cnt8),  32'd4);

      // ---- 2: valid on alternate cycles, 3 words; RUN ignores ld_valid
      do_reset();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         v8 = 1'b1; d8 = 32'h1000 + 32'(i); l8 = (i == 2);
         tick();
         check($sformatf("t2_we%0d", i),   32'(we8),   32'd1);
         check($sformatf("t2_addr%0d", i), 32'(addr8), 32'(i));
         check($sformatf("t2_data%0d", i), wd8,        32'h1000 + 32'(i));
         v8 = 1'b0; l8 = 1'b0;
         tick();
         check($sformatf("t2_gap%0d", i),  32'(we8),   32'd0);
      end
      tick();
      check("t2_done", 32'(done8), 32'd1);
      v8 = 1'b1; d8 = 32'hDEAD0000;
      tick();
      tick();
      check("t2_run_we",  32'(we8),   32'd0);
      check("t2_run_cnt", 32'(cnt8),  32'd3);
      check("t2_run_cpu", 32'(crst8), 32'd0);
      v8 = 1'b0;

      // ---- 3: ADDR_W=2, 5 words without ld_last -> overflow
      do_reset();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         v2 = 1'b1; d2 = 32'h300 + 32'(i); l2 = 1'b0;
         tick();
         check($sformatf("t3_we%0d", i),   32'(we2),   32'd1);
         check($sformatf("t3_addr%0d", i), 32'(addr2), 32'(i));
      end
      check("t3_err",   32'(err2),  32'd1);
      check("t3_ready", 32'(rdy2),  32'd0);
      check("t3_cpu",   32'(crst2), 32'd1);
      check("t3_done",  32'(done2), 32'd0);
      d2 = 32'h304;
      tick();
      check("t3_5th_we",  32'(we2),   32'd0);
      check("t3_5th_cnt", 32'(cnt2),  32'd4);
      tick();
      check("t3_err_hold", 32'(err2),  32'd1);
      check("t3_cpu_hold", 32'(crst2), 32'd1);
      v2 = 1'b0;

      // ---- 4: ADDR_W=2, ld_last on the word at the final address
      do_reset();
      check("t4_rst_err", 32'(err2), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         v2 = 1'b1; d2 = 32'h400 + 32'(i); l2 = (i == 3);
         tick();
      end
      v2 = 1'b0; l2 = 1'b0;
      check("t4_addr3", 32'(addr2), 32'd3);
      check("t4_we3",   32'(we2),   32'd1);
      check("t4_data3", wd2,        32'h403);
      check("t4_err0",  32'(err2),  32'd0);
      tick();
      tick();
      check("t4_done", 32'(done2), 32'd1);
      check("t4_err",  32'(err2),  32'd0);
      check("t4_cnt",  32'(cnt2),  32'd4);
      check("t4_cpu",  32'(crst2), 32'd0);

      // ---- 5: reset mid-load, then reload
      do_reset();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         v8 = 1'b1; d8 = prog[i]; l8 = 1'b0;
         tick();
      end
      v8 = 1'b0;
      check("t5_cnt_mid", 32'(cnt8), 32'd2);
      rst = 1'b1;
      tick();
      check("t5_rst_we",    32'(we8),   32'd0);
      check("t5_rst_addr",  32'(addr8), 32'd0);
      check("t5_rst_wdata", wd8,        32'd0);
      check("t5_rst_cnt",   32'(cnt8),  32'd0);
      check("t5_rst_cpu",   32'(crst8), 32'd1);
      rst = 1'b0;
      v8 = 1'b1; d8 = 32'hAAAA0001; l8 = 1'b0;
      tick();
      check("t5_addr0", 32'(addr8), 32'd0);
      check("t5_data0", wd8,        32'hAAAA0001);
      d8 = 32'hAAAA0002; l8 = 1'b1;
      tick();
      v8 = 1'b0; l8 = 1'b0;
      check("t5_addr1", 32'(addr8), 32'd1);
      check("t5_data1", wd8,        32'hAAAA0002);
      tick();
      tick();
      check("t5_done", 32'(done8), 32'd1);
      check("t5_cpu",  32'(crst8), 32'd0);

`ifdef LOADER_CHECKSUM_EN
      // ---- 6: checksum wraps modulo 2**32 and holds in RUN
      do_reset();
      check("t6_csum_rst", csum8, 32'd0);
      rst = 1'b0;
      v8 = 1'b1; d8 = 32'hFFFFFFFF; l8 = 1'b0;
      tick();
      check("t6_csum_1", csum8, 32'hFFFFFFFF);
      d8 = 32'h00000002; l8 = 1'b1;
      tick();
      v8 = 1'b0; l8 = 1'b0;
      check("t6_csum_2", csum8, 32'h00000001);
      tick();
      tick();
      tick();
      check("t6_done",     32'(done8), 32'd1);
      check("t6_csum_run", csum8,      32'h00000001);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #50000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
